mem_stage_sl: RTL

Parametrised memory-access pipeline stage for the LA32R five-stage core. It sits between EX and WB and handles data returned over a split-transaction SRAM-like data port: a load waits in MEM until `data_sram_data_ok` arrives. The stage buffers a response that arrives while WB is stalled and discards responses belonging to flushed instructions. It also aligns and extends sub-word loads and drives the MEM-to-ID forwarding/blocking signals.

---
 rtl/mem_stage_sl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_sl.sv
// mem_stage_sl: LA32R MEM pipeline stage.
// Waits for split-transaction data responses, buffers a response that arrives
// while WB is stalled, drops responses owed to flushed requests, aligns and
// extends sub-word loads, and drives MEM-to-ID forwarding/blocking.
module mem_stage_sl #(
   parameter int unsigned PC_W     = 32,
   parameter int unsigned CANCEL_W = 2,
   parameter int          FWD_EN   = 1
) (
   input  logic            clk,
   input  logic            resetn,
   // EX -> MEM
   input  logic            es_to_ms_valid,
   output logic            ms_allowin,
   input  logic [PC_W-1:0] es_pc,
   input  logic            es_gr_we,
   input  logic [4:0]      es_dest,
   input  logic [31:0]     es_alu_result,
   input  logic            es_res_from_mem,
   input  logic [1:0]      es_mem_size,
   input  logic            es_mem_unsigned,
   input  logic            es_req_issued,
   input  logic            es_ex,
   // data port response
   input  logic            data_sram_data_ok,
   input  logic [31:0]     data_sram_rdata,
   // flush from WB
   input  logic            ms_flush,
   // MEM -> WB
   output logic            ms_to_ws_valid,
   input  logic            ws_allowin,
   output logic [PC_W-1:0] ms_pc,
   output logic            ms_gr_we,
   output logic [4:0]      ms_dest,
   output logic            ms_ex,
   output logic [31:0]     ms_final_result,
   // forwarding to ID
   output logic            ms_fwd_valid,
   output logic [4:0]      ms_fwd_dest,
   output logic [31:0]     ms_fwd_data,
   output logic            ms_fwd_block
);

   logic                ms_valid;
   logic [31:0]         ms_alu_result;
   logic                ms_res_from_mem;
   logic [1:0]          ms_mem_size;
   logic                ms_mem_unsigned;
   logic                ms_req_issued;

   logic                buf_valid;
   logic [31:0]         buf_data;
   logic [CANCEL_W-1:0] discard_cnt;

   logic                ms_wait;
   logic                cnt_zero;
   logic                resp_discard;
   logic                resp_ms;
   logic                ms_ready_go;
   logic                ms_leave;
   logic                inc_wait;
   logic                inc_ex;
   logic [CANCEL_W-1:0] discard_cnt_next;

   logic [31:0]         load_word;
   logic [7:0]          load_byte;
   logic [15:0]         load_half;
   logic [31:0]         load_result;

   // Response ownership and handshake
   always_comb begin
      ms_wait      = ms_valid && ms_req_issued && !ms_ex && !buf_valid;
      cnt_zero     = (discard_cnt == '0);
      resp_discard = data_sram_data_ok && !cnt_zero;
      resp_ms      = data_sram_data_ok && cnt_zero && ms_wait;
      ms_ready_go  = !ms_wait || resp_ms;
      ms_allowin   = !ms_valid || (ms_ready_go && ws_allowin);
      ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush;
      ms_leave     = ms_valid && ms_ready_go && ws_allowin;
   end

   // Discard counter: one increment for each outstanding request killed by the flush
   always_comb begin
      inc_wait = ms_flush && ms_wait && !resp_ms;
      inc_ex   = ms_flush && es_to_ms_valid && es_req_issued && !es_ex;
      discard_cnt_next = discard_cnt + CANCEL_W'(inc_wait) + CANCEL_W'(inc_ex)
                         - CANCEL_W'(resp_discard);
   end

   // Stage valid and captured instruction fields; flush wins over capture
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid        <= 1'b0;
         ms_pc           <= '0;
         ms_gr_we        <= 1'b0;
         ms_dest         <= '0;
         ms_alu_result   <= '0;
         ms_res_from_mem <= 1'b0;
         ms_mem_size     <= '0;
         ms_mem_unsigned <= 1'b0;
         ms_req_issued   <= 1'b0;
         ms_ex           <= 1'b0;
      end else if (ms_flush) begin
         ms_valid <= 1'b0;
      end else if (ms_allowin) begin
         ms_valid <= es_to_ms_valid;
         if (es_to_ms_valid) begin
            ms_pc           <= es_pc;
            ms_gr_we        <= es_gr_we;
            ms_dest         <= es_dest;
            ms_alu_result   <= es_alu_result;
            ms_res_from_mem <= es_res_from_mem;
            ms_mem_size     <= es_mem_size;
            ms_mem_unsigned <= es_mem_unsigned;
            ms_req_issued   <= es_req_issued;
            ms_ex           <= es_ex;
         end
      end
   end

   // Response buffer for a MEM-owned response that WB cannot take yet
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         buf_valid <= 1'b0;
         buf_data  <= '0;
      end else if (ms_flush || ms_leave) begin
         buf_valid <= 1'b0;
      end else if (resp_ms && !ws_allowin) begin
         buf_valid <= 1'b1;
         buf_data  <= data_sram_rdata;
      end
   end

   // Outstanding-response discard counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         discard_cnt <= '0;
      end else begin
         discard_cnt <= discard_cnt_next;
      end
   end

   // Load alignment and extension
   always_comb begin
      load_word = buf_valid ? buf_data : data_sram_rdata;
      case (ms_alu_result[1:0])
         2'b00:   load_byte = load_word[7:0];
         2'b01:   load_byte = load_word[15:8];
         2'b10:   load_byte = load_word[23:16];
         default: load_byte = load_word[31:24];
      endcase
      load_half = ms_alu_result[1] ? load_word[31:16] : load_word[15:0];
      case (ms_mem_size)
         2'b00:   load_result = {{24{!ms_mem_unsigned && load_byte[7]}}, load_byte};
         2'b01:   load_result = {{16{!ms_mem_unsigned && load_half[15]}}, load_half};
         default: load_result = load_word;
      endcase
      ms_final_result = ms_res_from_mem ? load_result : ms_alu_result;
   end

   // Forwarding and load-use blocking toward ID
   generate
      if (FWD_EN != 0) begin : g_fwd
         always_comb begin
            ms_fwd_valid = ms_valid && ms_gr_we;
            ms_fwd_dest  = ms_dest;
            ms_fwd_data  = ms_final_result;
            ms_fwd_block = ms_fwd_valid && ms_res_from_mem && !ms_ready_go;
         end
      end else begin : g_no_fwd
         always_comb begin
            ms_fwd_valid = 1'b0;
            ms_fwd_dest  = '0;
            ms_fwd_data  = '0;
            ms_fwd_block = 1'b0;
         end
      end
   endgenerate

endmodule
